// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and widths for the instruction-fetch block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_lat_counter.sv
// ---------------------------------------------------------------------------
// fetch_lat_counter : memory read-latency counter, done on count RD_LAT-1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_lat_counter #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(RD_LAT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wraps to zero on the done cycle so the next access starts cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= done ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign done = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer : PC owner, fixed-latency imem sequencing, valid/ready out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                RD_LAT   = 2,
    parameter int unsigned       MEM_SIZE = 40,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] C_MEM_LIMIT = ADDR_W'(MEM_SIZE);

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic [ADDR_W-1:0]   r_instr_pc;
    logic                r_valid;
    logic                w_done;
    logic                w_capture;
    logic                w_handshake;
    logic [ADDR_W-1:0]   w_target;

    assign w_target = redirect_pc & ~ADDR_W'(3);

    fetch_lat_counter #(
        .RD_LAT (RD_LAT)
    ) u_lat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (redirect),
        .en    (r_state == FETCH),
        .done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Redirect overrides any capture or handshake decided for this cycle.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            FETCH: begin
                if (w_done) begin
                    w_capture    = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = (r_pc >= C_MEM_LIMIT) ? HALT : FETCH;
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = FETCH;
        endcase
        if (redirect) begin
            w_capture    = 1'b0;
            w_handshake  = 1'b0;
            w_next_state = (w_target >= C_MEM_LIMIT) ? HALT : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else if (redirect) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_instr    <= imem_instr;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + PC_STEP;
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = (r_state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : directed self-checking bench for fetch_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h5800000F;
            32'd4:   return 32'h58080010;
            32'd8:   return 32'h00000013;
            32'd12:  return 32'h10009000;
            32'd16:  return 32'h08000002;
            default: return 32'h0;
        endcase
    endfunction

    // DUT A: RD_LAT=2, MEM_SIZE=20
    logic        rst_n_a = 1'b0, ready_a = 1'b0, redirect_a = 1'b0, valid_a, halted_a;
    logic [31:0] redirect_pc_a = '0, imem_addr_a, imem_instr_a, instr_a, instr_pc_a;
    assign imem_instr_a = rom(imem_addr_a);

    fetch_sequencer #(.RD_LAT(2), .MEM_SIZE(20), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .imem_addr(imem_addr_a), .imem_instr(imem_instr_a),
        .instr(instr_a), .instr_pc(instr_pc_a), .instr_valid(valid_a), .instr_ready(ready_a),
        .redirect(redirect_a), .redirect_pc(redirect_pc_a), .halted(halted_a));

    // DUT B: RD_LAT=2, MEM_SIZE=40
    logic        rst_n_b = 1'b0, ready_b = 1'b0, redirect_b = 1'b0, valid_b, halted_b;
    logic [31:0] redirect_pc_b = '0, imem_addr_b, imem_instr_b, instr_b, instr_pc_b;
    assign imem_instr_b = rom(imem_addr_b);

    fetch_sequencer #(.RD_LAT(2), .MEM_SIZE(40), .RESET_PC(32'h0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
        .instr(instr_b), .instr_pc(instr_pc_b), .instr_valid(valid_b), .instr_ready(ready_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b), .halted(halted_b));

    // DUT C: RD_LAT=1, MEM_SIZE=40
    logic        rst_n_c = 1'b0, ready_c = 1'b0, redirect_c = 1'b0, valid_c, halted_c;
    logic [31:0] redirect_pc_c = '0, imem_addr_c, imem_instr_c, instr_c, instr_pc_c;
    assign imem_instr_c = rom(imem_addr_c);

    fetch_sequencer #(.RD_LAT(1), .MEM_SIZE(40), .RESET_PC(32'h0)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .imem_addr(imem_addr_c), .imem_instr(imem_instr_c),
        .instr(instr_c), .instr_pc(instr_pc_c), .instr_valid(valid_c), .instr_ready(ready_c),
        .redirect(redirect_c), .redirect_pc(redirect_pc_c), .halted(halted_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0; ready_a = 1'b0; redirect_a = 1'b0;
        step(); step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr_a); end
        checks++; if (instr_pc_a !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc_a); end
        checks++; if (halted_a !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted_a); end
        checks++; if (imem_addr_a !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr_a); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [5];
        logic [31:0] exp_in [5];
        logic        exp_v, exp_h;
        int          idx;
        exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
        exp_in = '{32'h5800000F, 32'h58080010, 32'h00000013, 32'h10009000, 32'h08000002};
        idx = 0;
        rst_n_a = 1'b1; ready_a = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_v = (k % 3 == 2) && (k <= 14);
            exp_h = (k >= 15);
            checks++; if (valid_a !== exp_v) begin errors++; $display("FAIL stream_valid cyc %0d: got %b expected %b", k, valid_a, exp_v); end
            checks++; if (halted_a !== exp_h) begin errors++; $display("FAIL stream_halted cyc %0d: got %b expected %b", k, halted_a, exp_h); end
            if (exp_v) begin
                checks++; if (instr_pc_a !== exp_pc[idx]) begin errors++; $display("FAIL stream_pc cyc %0d: got %h expected %h", k, instr_pc_a, exp_pc[idx]); end
                checks++; if (instr_a !== exp_in[idx]) begin errors++; $display("FAIL stream_instr cyc %0d: got %h expected %h", k, instr_a, exp_in[idx]); end
                idx++;
            end
        end
        checks++; if (imem_addr_a !== 32'd20) begin errors++; $display("FAIL halt_pc_frozen: got %h expected 14", imem_addr_a); end
    endtask

    task automatic test_backpressure();
        rst_n_a = 1'b0; step();
        rst_n_a = 1'b1; ready_a = 1'b1;
        repeat (5) step();
        checks++; if (valid_a !== 1'b1 || instr_pc_a !== 32'd4) begin errors++; $display("FAIL bp_first: got v=%b pc=%h expected v=1 pc=4", valid_a, instr_pc_a); end
        ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (valid_a !== 1'b1 || instr_a !== 32'h58080010 || instr_pc_a !== 32'd4 || imem_addr_a !== 32'd8) begin
                errors++;
                $display("FAIL bp_hold %0d: got v=%b instr=%h pc=%h addr=%h expected v=1 instr=58080010 pc=4 addr=8",
                         i, valid_a, instr_a, instr_pc_a, imem_addr_a);
            end
        end
        ready_a = 1'b1;
        step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL bp_handshake: got v=%b expected 0", valid_a); end
        step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL bp_gap: got v=%b expected 0", valid_a); end
        step();
        checks++;
        if (valid_a !== 1'b1 || instr_pc_a !== 32'd8 || instr_a !== 32'h00000013) begin
            errors++; $display("FAIL bp_next: got v=%b pc=%h instr=%h expected v=1 pc=8 instr=00000013", valid_a, instr_pc_a, instr_a);
        end
    endtask

    task automatic test_redirect_handshake();
        rst_n_a = 1'b0; step();
        rst_n_a = 1'b1; ready_a = 1'b1;
        repeat (5) step();
        checks++; if (valid_a !== 1'b1 || instr_pc_a !== 32'd4) begin errors++; $display("FAIL rd_pre: got v=%b pc=%h expected v=1 pc=4", valid_a, instr_pc_a); end
        redirect_a = 1'b1; redirect_pc_a = 32'h12;
        step();
        redirect_a = 1'b0;
        checks++; if (valid_a !== 1'b0 || imem_addr_a !== 32'h10) begin errors++; $display("FAIL rd_discard: got v=%b addr=%h expected v=0 addr=10", valid_a, imem_addr_a); end
        step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rd_wait: got v=%b expected 0", valid_a); end
        step();
        checks++;
        if (valid_a !== 1'b1 || instr_pc_a !== 32'h10 || instr_a !== 32'h08000002) begin
            errors++; $display("FAIL rd_target: got v=%b pc=%h instr=%h expected v=1 pc=10 instr=08000002", valid_a, instr_pc_a, instr_a);
        end
    endtask

    task automatic test_redirect_halt();
        rst_n_b = 1'b0; step();
        rst_n_b = 1'b1; ready_b = 1'b1;
        step();
        redirect_b = 1'b1; redirect_pc_b = 32'h40;
        step();
        redirect_b = 1'b0;
        checks++; if (halted_b !== 1'b1 || valid_b !== 1'b0 || imem_addr_b !== 32'h40) begin
            errors++; $display("FAIL rh_halt: got h=%b v=%b addr=%h expected h=1 v=0 addr=40", halted_b, valid_b, imem_addr_b); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (halted_b !== 1'b1 || valid_b !== 1'b0) begin errors++; $display("FAIL rh_stay %0d: got h=%b v=%b expected h=1 v=0", i, halted_b, valid_b); end
        end
        redirect_b = 1'b1; redirect_pc_b = 32'h0;
        step();
        redirect_b = 1'b0;
        checks++; if (halted_b !== 1'b0 || valid_b !== 1'b0) begin errors++; $display("FAIL rh_restart: got h=%b v=%b expected h=0 v=0", halted_b, valid_b); end
        step();
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL rh_wait: got v=%b expected 0", valid_b); end
        step();
        checks++; if (valid_b !== 1'b1 || instr_pc_b !== 32'h0 || instr_b !== 32'h5800000F) begin
            errors++; $display("FAIL rh_first: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=5800000F", valid_b, instr_pc_b, instr_b); end
        redirect_b = 1'b1; redirect_pc_b = 32'h2B;
        step();
        checks++; if (halted_b !== 1'b1 || imem_addr_b !== 32'h28) begin errors++; $display("FAIL rh_edge_hi: got h=%b addr=%h expected h=1 addr=28", halted_b, imem_addr_b); end
        redirect_pc_b = 32'h27;
        step();
        redirect_b = 1'b0;
        checks++; if (halted_b !== 1'b0 || imem_addr_b !== 32'h24) begin errors++; $display("FAIL rh_edge_lo: got h=%b addr=%h expected h=0 addr=24", halted_b, imem_addr_b); end
    endtask

    task automatic test_reset_mid();
        rst_n_a = 1'b0; ready_a = 1'b0; step();
        rst_n_a = 1'b1; step();
        rst_n_a = 1'b0; step();
        checks++; if (valid_a !== 1'b0 || instr_a !== 32'h0 || instr_pc_a !== 32'h0 || halted_a !== 1'b0 || imem_addr_a !== 32'h0) begin
            errors++; $display("FAIL rst_fetch: got v=%b instr=%h pc=%h h=%b addr=%h expected all 0",
                               valid_a, instr_a, instr_pc_a, halted_a, imem_addr_a); end
        rst_n_a = 1'b1; step(); step();
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL rst_hold_pre: got v=%b expected 1", valid_a); end
        rst_n_a = 1'b0; step();
        checks++; if (valid_a !== 1'b0 || instr_a !== 32'h0 || instr_pc_a !== 32'h0 || halted_a !== 1'b0 || imem_addr_a !== 32'h0) begin
            errors++; $display("FAIL rst_hold: got v=%b instr=%h pc=%h h=%b addr=%h expected all 0",
                               valid_a, instr_a, instr_pc_a, halted_a, imem_addr_a); end
        rst_n_a = 1'b1; step(); step();
        checks++; if (valid_a !== 1'b1 || instr_pc_a !== 32'h0) begin errors++; $display("FAIL rst_refetch: got v=%b pc=%h expected v=1 pc=0", valid_a, instr_pc_a); end
    endtask

    task automatic test_rd_lat1();
        logic        exp_v;
        logic [31:0] exp_pc;
        rst_n_c = 1'b0; step();
        rst_n_c = 1'b1; ready_c = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_v  = (k % 2 == 1);
            exp_pc = 32'((k - 1) / 2 * 4);
            checks++; if (valid_c !== exp_v) begin errors++; $display("FAIL lat1_valid cyc %0d: got %b expected %b", k, valid_c, exp_v); end
            if (exp_v) begin
                checks++; if (instr_pc_c !== exp_pc) begin errors++; $display("FAIL lat1_pc cyc %0d: got %h expected %h", k, instr_pc_c, exp_pc); end
            end
        end
        checks++; if (instr_c !== 32'h00000013) begin errors++; $display("FAIL lat1_instr: got %h expected 00000013", instr_c); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_handshake();
        test_redirect_halt();
        test_reset_mid();
        test_rd_lat1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
